// File: rtl/hex_display_scan.sv
// Multi-digit hex 7-segment driver: parallel outputs for every digit
// plus one time-multiplexed scanned digit, with leading-zero blanking and blink.
module hex_display_scan #(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Load,
  input  logic [4*NDIG-1:0]   Value,
  input  logic                Blank_lz,
  input  logic [NDIG-1:0]     Blink_en,
  output logic [0:6]          Seg,
  output logic [NDIG-1:0]     Dig_sel,
  output logic [7*NDIG-1:0]   Hex_all
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [0:6] seg_code(input logic [3:0] n);
    logic [0:6] c;
    case (n)
      4'h0:    c = 7'b0000001;
      4'h1:    c = 7'b1001111;
      4'h2:    c = 7'b0010010;
      4'h3:    c = 7'b0000110;
      4'h4:    c = 7'b1001100;
      4'h5:    c = 7'b0100100;
      4'h6:    c = 7'b0100000;
      4'h7:    c = 7'b0001101;
      4'h8:    c = 7'b0000000;
      4'h9:    c = 7'b0000100;
      4'hA:    c = 7'b0001000;
      4'hB:    c = 7'b1100000;
      4'hC:    c = 7'b0110001;
      4'hD:    c = 7'b1000010;
      4'hE:    c = 7'b0110000;
      default: c = 7'b0111000;
    endcase
    return c;
  endfunction

  logic [4*NDIG-1:0] value_q;
  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     frame;
  logic              phase;

  logic              scan_tc;
  logic              idx_last;
  logic              frame_last;
  logic [NDIG-1:0]   blank;
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic [NDIG-1:0]   sel_nxt;
  logic [7*NDIG-1:0] hex_nxt;

  assign scan_tc    = (pre == PW'(SCAN_DIV - 1));
  assign idx_last   = (idx == IW'(NDIG - 1));
  assign frame_last = (frame == FW'(BLINK_FRAMES - 1));

  // Digit i is a leading zero when it and every higher nibble are zero
  always_comb begin
    blank = '0;
    for (int i = 0; i < NDIG; i++) begin
      blank[i] = phase & Blink_en[i];
      if (i > 0 && Blank_lz && ((value_q >> (4 * i)) == '0))
        blank[i] = 1'b1;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    sel_nxt   = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = value_q[4*i +: 4];
        cur_blank  = blank[i];
        sel_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    hex_nxt = '1;
    for (int i = 0; i < NDIG; i++) begin
      logic [0:6] c;
      c = '1;
      if (!blank[i])
        c = seg_code(value_q[4*i +: 4]);
      for (int k = 0; k < 7; k++)
        hex_nxt[7*i+k] = c[k];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      value_q <= '0;
    end else if (Load) begin
      value_q <= Value;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pre   <= '0;
      idx   <= '0;
      frame <= '0;
      phase <= 1'b0;
    end else begin
      pre <= scan_tc ? '0 : pre + 1'b1;
      if (scan_tc) begin
        idx <= idx_last ? '0 : idx + 1'b1;
        if (idx_last) begin
          frame <= frame_last ? '0 : frame + 1'b1;
          if (frame_last)
            phase <= ~phase;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Seg     <= '1;
      Dig_sel <= '1;
      Hex_all <= '1;
    end else begin
      Seg     <= cur_blank ? 7'b1111111 : seg_code(cur_nib);
      Dig_sel <= sel_nxt;
      Hex_all <= hex_nxt;
    end
  end

endmodule
